// File: rtl/bcd_in_if.sv
// Handshake and data bundle between a requester and the BCD-to-binary converter.
// The requester drives entrada and ler; the converter returns the result and status flags.
interface bcd_in_if #(
  parameter int N_DIGITOS = 4
);
  logic [4*N_DIGITOS-1:0] entrada;
  logic                   ler;
  logic [31:0]            saida;
  logic                   pronto;
  logic                   ocupado;
  logic                   erro;

  modport master (
    output entrada,
    output ler,
    input  saida,
    input  pronto,
    input  ocupado,
    input  erro
  );

  modport slave (
    input  entrada,
    input  ler,
    output saida,
    output pronto,
    output ocupado,
    output erro
  );
endinterface

// File: rtl/bcd_in.sv
// Packed-BCD to binary converter using reverse double-dabble.
// One bit is shifted per CONV cycle, and invalid digits bypass conversion.
module bcd_in #(
  parameter int N_DIGITOS = 4
) (
  input  logic clock,
  input  logic reset_n,
  bcd_in_if.slave io
);

  localparam int W = 4 * N_DIGITOS;
  localparam logic [5:0] LAST = 6'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2*W-1:0] sr_q, sr_d;
  logic [2*W-1:0] stepped;
  logic [5:0]     cnt_q, cnt_d;
  logic [31:0]    saida_q, saida_d;
  logic           bad_q, bad_d;
  logic           erro_q, erro_d;
  logic           pronto_q, pronto_d;
  logic           has_bad;

  always_comb begin
    has_bad = 1'b0;
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (io.entrada[4*k +: 4] > 4'd9) begin
        has_bad = 1'b1;
      end
    end
  end

  // A nibble of 8 or more after the shift held a 1 carried down from the
  // next higher digit; it must be worth 5 here, not 8.
  always_comb begin
    stepped = sr_q >> 1;
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (stepped[W + 4*k + 3]) begin
        stepped[W + 4*k +: 4] = stepped[W + 4*k +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    saida_d  = saida_q;
    erro_d   = erro_q;
    pronto_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.ler) begin
          sr_d    = {io.entrada, {W{1'b0}}};
          cnt_d   = '0;
          bad_d   = has_bad;
          state_d = has_bad ? DONE : CONV;
        end
      end
      CONV: begin
        sr_d  = stepped;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        saida_d  = bad_q ? 32'd0 : 32'(sr_q[W-1:0]);
        erro_d   = bad_q;
        pronto_d = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      saida_q  <= '0;
      erro_q   <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      saida_q  <= saida_d;
      erro_q   <= erro_d;
      pronto_q <= pronto_d;
    end
  end

  assign io.saida   = saida_q;
  assign io.erro    = erro_q;
  assign io.pronto  = pronto_q;
  assign io.ocupado = (state_q != IDLE);

endmodule

// File: doc/bcd_in.md
BCD_IN -- requirements
Module: bcd_in

Interface
REQ-001 SHALL have parameter N_DIGITOS, default 4, number of packed BCD input digits (legal range 1..8).
REQ-002 SHALL have port clock  input  1  rising-edge clock, the only clock of the block.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port entrada  input  4*N_DIGITOS  packed BCD digits; nibble 0 [3:0] = units, nibble k = 10^k.
REQ-005 SHALL have port ler  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port saida  output  32  binary result, zero-extended.
REQ-007 SHALL have port pronto  output  1  one-cycle completion pulse.
REQ-008 SHALL have port ocupado  output  1  high while a conversion is in progress.
REQ-009 SHALL have port erro  output  1  invalid-digit flag for the last request.

Function
REQ-010 SHALL implement the FSM states IDLE, CONV and DONE, with all state, counter and output registers clocked on the rising edge of clock.
REQ-011 In IDLE with ler=1, SHALL at that edge capture entrada into the BCD half of a 8*N_DIGITOS-bit shift register, clear the binary half, clear the step counter and check every nibble.
REQ-012 If any captured nibble exceeds 9, SHALL go to DONE at that edge, skip CONV, and at the next edge set saida=0 and erro=1.
REQ-013 If all captured nibbles are 0..9, SHALL go to CONV and set erro=0.
REQ-014 Each CONV edge SHALL perform one reverse double-dabble step:
- shift the whole register right by 1, BCD MSB-side filled with 0;
- then subtract 3 from every BCD nibble whose post-shift value is >= 8.
REQ-015 CONV SHALL last exactly 4*N_DIGITOS edges, after which the FSM SHALL enter DONE.
REQ-016 The DONE edge SHALL load saida with the binary half (zero-extended to 32 bits) and SHALL return the FSM to IDLE.
REQ-017 pronto SHALL be high for exactly the one cycle following the DONE edge.
REQ-018 Latency from the capturing edge to pronto high SHALL be 4*N_DIGITOS+1 edges for a valid request and 1 edge for an invalid request (17 and 1 for N_DIGITOS=4).
REQ-019 ocupado SHALL be 1 in CONV and DONE and 0 in IDLE.
REQ-020 ler asserted while ocupado=1 SHALL be ignored, with no queuing and no restart.
REQ-021 ler held high continuously SHALL start a new conversion on the first edge after pronto, when the FSM is back in IDLE.
REQ-022 saida and erro SHALL hold their values between completions and change only at a DONE edge.
REQ-023 A change on entrada after the capturing edge SHALL NOT affect the conversion in progress.

Reset
REQ-024 reset_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, counter=0, shift register=0, saida=0, pronto=0, ocupado=0 and erro=0.
REQ-025 Reset asserted mid-conversion SHALL abort that conversion with no pronto pulse.
REQ-026 After reset_n deasserts, the first ler sampled high in IDLE SHALL start a fresh conversion.

Verification (N_DIGITOS=4)
REQ-027 Scenario: entrada=16'h1234, ler pulse -> ocupado rises, pronto high exactly 17 edges after capture, saida=32'd1234 (0x4D2), erro=0.
REQ-028 Scenario: entrada=16'h9999 -> saida=32'd9999 (0x270F), erro=0; entrada=16'h0000 -> saida=0, erro=0, with the same 17-edge latency.
REQ-029 Scenario: entrada=16'h12A4 -> pronto 1 edge after capture, saida=0, erro=1, ocupado low again the cycle after pronto.
REQ-030 Scenario: ler pulsed again at edges 5 and 16 of a 16'h0042 conversion, and entrada changed to 16'h9999 at edge 3 -> a single pronto, saida=32'd42.
REQ-031 Scenario: reset_n low at edge 8 of a 16'h5678 conversion -> outputs zero asynchronously and no pronto; 16'h0007 after release -> saida=32'd7.
REQ-032 Scenario: ler held high across three conversions of 16'h0100 -> pronto pulses spaced exactly 18 edges apart, each with saida=32'd100.
